// File: rtl/mem_pkg.sv
// Shared types and widths for the memory-access stage and its MEM/WB register.
package mem_pkg;

    localparam int DATA_W    = 16;
    localparam int REG_SEL_W = 4;

    typedef enum logic {
        IDLE,
        WAIT
    } mem_state_t;

    // Timeout counter must hold ACK_TIMEOUT itself; keep at least one bit when the timeout is disabled.
    function automatic int cnt_width(input int timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register: inserts a bubble (write disabled, data/select held) while the stage stalls.
module mem_wb_reg
    import mem_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic                 regwrite,
    input  logic [DATA_W-1:0]    write_data,
    input  logic [REG_SEL_W-1:0] write_select,
    output logic                 regwrite_wb,
    output logic [DATA_W-1:0]    reg_write_data_wb,
    output logic [REG_SEL_W-1:0] reg_write_select_wb
);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            regwrite_wb         <= 1'b0;
            reg_write_data_wb   <= '0;
            reg_write_select_wb <= '0;
        end else if (stall) begin
            regwrite_wb <= 1'b0;
        end else begin
            regwrite_wb         <= regwrite;
            reg_write_data_wb   <= write_data;
            reg_write_select_wb <= write_select;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: one load/store per instruction over a req/ack port, with stall and timeout.
// Optional feature: define MEM_STALL_CNT_EN to add the saturating stall_cnt output.
module mem_stage
    import mem_pkg::*;
#(
    parameter int ACK_TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 regwrite_in,
    input  logic                 memtoreg_in,
    input  logic                 memwrite_in,
    input  logic [DATA_W-1:0]    mem_addr_in,
    input  logic [DATA_W-1:0]    store_data_in,
    input  logic [DATA_W-1:0]    alu_result_in,
    input  logic [REG_SEL_W-1:0] reg_write_select_in,
    output logic                 dmem_req,
    output logic                 dmem_we,
    output logic [DATA_W-1:0]    dmem_addr,
    output logic [DATA_W-1:0]    dmem_wdata,
    input  logic [DATA_W-1:0]    dmem_rdata,
    input  logic                 dmem_ack,
    output logic                 mem_stall,
    output logic                 mem_err,
    output logic                 regwrite_wb,
    output logic [DATA_W-1:0]    reg_write_data_wb,
    output logic [REG_SEL_W-1:0] reg_write_select_wb
`ifdef MEM_STALL_CNT_EN
    ,
    output logic [15:0]          stall_cnt
`endif
);

    localparam int               CNT_W       = cnt_width(ACK_TIMEOUT);
    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(ACK_TIMEOUT);

    mem_state_t        state;
    logic [CNT_W-1:0]  ack_cnt;
    logic              access;
    logic              timed_out;
    logic              complete;
    logic [DATA_W-1:0] wb_data;

    assign access    = memtoreg_in | memwrite_in;
    assign timed_out = (state == WAIT) && !dmem_ack && (ACK_TIMEOUT != 0) && (ack_cnt == TIMEOUT_VAL);

    // Gating with rst drops the request the moment reset asserts, even though the inputs are still held.
    assign dmem_req   = rst & ((state == WAIT) | access);
    assign dmem_we    = dmem_req & memwrite_in;
    assign dmem_addr  = dmem_req ? mem_addr_in   : '0;
    assign dmem_wdata = dmem_req ? store_data_in : '0;

    assign complete  = dmem_req & (dmem_ack | timed_out);
    assign mem_stall = dmem_req & ~complete;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            ack_cnt <= '0;
            mem_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (access && !dmem_ack) begin
                        state   <= WAIT;
                        ack_cnt <= CNT_W'(1);
                    end
                end
                WAIT: begin
                    if (dmem_ack) begin
                        state <= IDLE;
                    end else if (timed_out) begin
                        mem_err <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        ack_cnt <= ack_cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: assign a default first in always_comb so no path leaves wb_data unassigned (no latch).
    always_comb begin
        wb_data = alu_result_in;
        if (memtoreg_in) begin
            wb_data = timed_out ? '0 : dmem_rdata;
        end
    end

    mem_wb_reg u_mem_wb_reg (
        .clk                 (clk),
        .rst                 (rst),
        .stall               (mem_stall),
        .regwrite            (regwrite_in),
        .write_data          (wb_data),
        .write_select        (reg_write_select_in),
        .regwrite_wb         (regwrite_wb),
        .reg_write_data_wb   (reg_write_data_wb),
        .reg_write_select_wb (reg_write_select_wb)
    );

`ifdef MEM_STALL_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (mem_stall && stall_cnt != 16'hFFFF) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage (ACK_TIMEOUT=4): ALU pass-through, store, waited load, timeout abort, reset.
module tb_mem_stage;

    logic        clk;
    logic        rst;
    logic        regwrite_in;
    logic        memtoreg_in;
    logic        memwrite_in;
    logic [15:0] mem_addr_in;
    logic [15:0] store_data_in;
    logic [15:0] alu_result_in;
    logic [3:0]  reg_write_select_in;
    logic        dmem_req;
    logic        dmem_we;
    logic [15:0] dmem_addr;
    logic [15:0] dmem_wdata;
    logic [15:0] dmem_rdata;
    logic        dmem_ack;
    logic        mem_stall;
    logic        mem_err;
    logic        regwrite_wb;
    logic [15:0] reg_write_data_wb;
    logic [3:0]  reg_write_select_wb;
`ifdef MEM_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    mem_stage #(.ACK_TIMEOUT(4)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .regwrite_in         (regwrite_in),
        .memtoreg_in         (memtoreg_in),
        .memwrite_in         (memwrite_in),
        .mem_addr_in         (mem_addr_in),
        .store_data_in       (store_data_in),
        .alu_result_in       (alu_result_in),
        .reg_write_select_in (reg_write_select_in),
        .dmem_req            (dmem_req),
        .dmem_we             (dmem_we),
        .dmem_addr           (dmem_addr),
        .dmem_wdata          (dmem_wdata),
        .dmem_rdata          (dmem_rdata),
        .dmem_ack            (dmem_ack),
        .mem_stall           (mem_stall),
        .mem_err             (mem_err),
        .regwrite_wb         (regwrite_wb),
        .reg_write_data_wb   (reg_write_data_wb),
        .reg_write_select_wb (reg_write_select_wb)
`ifdef MEM_STALL_CNT_EN
        ,
        .stall_cnt           (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive_nop();
        regwrite_in         = 1'b0;
        memtoreg_in         = 1'b0;
        memwrite_in         = 1'b0;
        mem_addr_in         = 16'h0000;
        store_data_in       = 16'h0000;
        alu_result_in       = 16'h0000;
        reg_write_select_in = 4'd0;
        dmem_rdata          = 16'h0000;
        dmem_ack            = 1'b0;
    endtask

    task automatic drive_load(input logic [15:0] addr, input logic [3:0] sel);
        drive_nop();
        regwrite_in         = 1'b1;
        memtoreg_in         = 1'b1;
        mem_addr_in         = addr;
        alu_result_in       = 16'hFFFF;
        reg_write_select_in = sel;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        drive_nop();
        #3;
        checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", dmem_req); end
        checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", mem_stall); end
        checks++; if (mem_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", mem_err); end
        checks++; if (regwrite_wb !== 1'b0) begin errors++; $display("FAIL reset_regwrite_wb: got %b expected 0", regwrite_wb); end
        checks++; if (reg_write_data_wb !== 16'h0000) begin errors++; $display("FAIL reset_wb_data: got %h expected 0000", reg_write_data_wb); end
        checks++; if (reg_write_select_wb !== 4'd0) begin errors++; $display("FAIL reset_wb_sel: got %0d expected 0", reg_write_select_wb); end
`ifdef MEM_STALL_CNT_EN
        checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL reset_stall_cnt: got %0d expected 0", stall_cnt); end
`endif
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_alu_op();
        drive_nop();
        regwrite_in         = 1'b1;
        reg_write_select_in = 4'd3;
        alu_result_in       = 16'h1234;
        #1;
        checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL alu_req: got %b expected 0", dmem_req); end
        checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL alu_stall: got %b expected 0", mem_stall); end
        @(negedge clk);
        checks++; if (regwrite_wb !== 1'b1) begin errors++; $display("FAIL alu_regwrite_wb: got %b expected 1", regwrite_wb); end
        checks++; if (reg_write_data_wb !== 16'h1234) begin errors++; $display("FAIL alu_wb_data: got %h expected 1234", reg_write_data_wb); end
        checks++; if (reg_write_select_wb !== 4'd3) begin errors++; $display("FAIL alu_wb_sel: got %0d expected 3", reg_write_select_wb); end
        drive_nop();
        @(negedge clk);
        checks++; if (regwrite_wb !== 1'b0) begin errors++; $display("FAIL nop_regwrite_wb: got %b expected 0", regwrite_wb); end
    endtask

    task automatic test_store_zero_wait();
        drive_nop();
        memwrite_in   = 1'b1;
        mem_addr_in   = 16'h0040;
        store_data_in = 16'hBEEF;
        alu_result_in = 16'h0040;
        dmem_ack      = 1'b1;
        #1;
        checks++; if (dmem_req !== 1'b1) begin errors++; $display("FAIL store_req: got %b expected 1", dmem_req); end
        checks++; if (dmem_we !== 1'b1) begin errors++; $display("FAIL store_we: got %b expected 1", dmem_we); end
        checks++; if (dmem_addr !== 16'h0040) begin errors++; $display("FAIL store_addr: got %h expected 0040", dmem_addr); end
        checks++; if (dmem_wdata !== 16'hBEEF) begin errors++; $display("FAIL store_wdata: got %h expected beef", dmem_wdata); end
        checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL store_stall: got %b expected 0", mem_stall); end
        @(negedge clk);
        drive_nop();
        #1;
        checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL store_done_req: got %b expected 0", dmem_req); end
        checks++; if (dmem_wdata !== 16'h0000) begin errors++; $display("FAIL store_idle_wdata: got %h expected 0000", dmem_wdata); end
        checks++; if (regwrite_wb !== 1'b0) begin errors++; $display("FAIL store_regwrite_wb: got %b expected 0", regwrite_wb); end
        @(negedge clk);
    endtask

    task automatic test_load_wait();
        int stalls = 0;
`ifdef MEM_STALL_CNT_EN
        logic [15:0] cnt_before;
        cnt_before = stall_cnt;
`endif
        drive_load(16'h0010, 4'd5);
        for (int c = 0; c < 3; c++) begin
            #1;
            if (mem_stall === 1'b1) stalls++;
            checks++; if (dmem_req !== 1'b1 || dmem_we !== 1'b0 || dmem_addr !== 16'h0010) begin
                errors++; $display("FAIL load_req_c%0d: got req=%b we=%b addr=%h expected 1/0/0010", c, dmem_req, dmem_we, dmem_addr);
            end
            @(negedge clk);
            checks++; if (regwrite_wb !== 1'b0) begin errors++; $display("FAIL load_bubble_c%0d: got %b expected 0", c, regwrite_wb); end
        end
        dmem_ack   = 1'b1;
        dmem_rdata = 16'h00A5;
        #1;
        if (mem_stall === 1'b1) stalls++;
        checks++; if (stalls != 3) begin errors++; $display("FAIL load_stall_cycles: got %0d expected 3", stalls); end
        @(negedge clk);
        drive_nop();
        checks++; if (regwrite_wb !== 1'b1) begin errors++; $display("FAIL load_regwrite_wb: got %b expected 1", regwrite_wb); end
        checks++; if (reg_write_data_wb !== 16'h00A5) begin errors++; $display("FAIL load_wb_data: got %h expected 00a5", reg_write_data_wb); end
        checks++; if (reg_write_select_wb !== 4'd5) begin errors++; $display("FAIL load_wb_sel: got %0d expected 5", reg_write_select_wb); end
        @(negedge clk);
        checks++; if (regwrite_wb !== 1'b0) begin errors++; $display("FAIL load_single_wb: got %b expected 0", regwrite_wb); end
`ifdef MEM_STALL_CNT_EN
        checks++; if (stall_cnt !== cnt_before + 16'd3) begin errors++; $display("FAIL stall_cnt: got %0d expected %0d", stall_cnt, cnt_before + 16'd3); end
`endif
    endtask

    task automatic test_load_store_both();
        drive_nop();
        regwrite_in         = 1'b1;
        memtoreg_in         = 1'b1;
        memwrite_in         = 1'b1;
        mem_addr_in         = 16'h0022;
        store_data_in       = 16'h7777;
        alu_result_in       = 16'h1111;
        reg_write_select_in = 4'd2;
        dmem_ack            = 1'b1;
        dmem_rdata          = 16'h5A5A;
        #1;
        checks++; if (dmem_we !== 1'b1) begin errors++; $display("FAIL both_we: got %b expected 1", dmem_we); end
        @(negedge clk);
        drive_nop();
        checks++; if (reg_write_data_wb !== 16'h5A5A) begin errors++; $display("FAIL both_wb_data: got %h expected 5a5a", reg_write_data_wb); end
        @(negedge clk);
    endtask

    task automatic test_timeout();
        drive_load(16'h0030, 4'd7);
        dmem_rdata = 16'h1234;
        // Request cycle plus WAIT counts 1..3 stall; WAIT count 4 aborts.
        for (int c = 0; c < 4; c++) begin
            #1;
            checks++; if (mem_stall !== 1'b1) begin errors++; $display("FAIL timeout_stall_c%0d: got %b expected 1", c, mem_stall); end
            @(negedge clk);
        end
        #1;
        checks++; if (mem_stall !== 1'b0 || dmem_req !== 1'b1) begin
            errors++; $display("FAIL timeout_abort_cycle: got stall=%b req=%b expected 0/1", mem_stall, dmem_req);
        end
        checks++; if (mem_err !== 1'b0) begin errors++; $display("FAIL timeout_err_early: got %b expected 0", mem_err); end
        @(negedge clk);
        drive_nop();
        checks++; if (mem_err !== 1'b1) begin errors++; $display("FAIL timeout_err: got %b expected 1", mem_err); end
        checks++; if (regwrite_wb !== 1'b1) begin errors++; $display("FAIL timeout_regwrite_wb: got %b expected 1", regwrite_wb); end
        checks++; if (reg_write_data_wb !== 16'h0000) begin errors++; $display("FAIL timeout_wb_data: got %h expected 0000", reg_write_data_wb); end
        checks++; if (reg_write_select_wb !== 4'd7) begin errors++; $display("FAIL timeout_wb_sel: got %0d expected 7", reg_write_select_wb); end
        repeat (3) @(negedge clk);
        checks++; if (mem_err !== 1'b1) begin errors++; $display("FAIL timeout_err_sticky: got %b expected 1", mem_err); end
        checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL timeout_idle_req: got %b expected 0", dmem_req); end
    endtask

    task automatic test_reset_mid_access();
        drive_load(16'h0020, 4'd9);
        repeat (2) @(negedge clk);
        checks++; if (dmem_req !== 1'b1 || mem_stall !== 1'b1) begin
            errors++; $display("FAIL midrst_pre: got req=%b stall=%b expected 1/1", dmem_req, mem_stall);
        end
        #2;
        rst = 1'b0;
        #1;
        checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL midrst_req: got %b expected 0", dmem_req); end
        checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL midrst_stall: got %b expected 0", mem_stall); end
        checks++; if (regwrite_wb !== 1'b0) begin errors++; $display("FAIL midrst_regwrite_wb: got %b expected 0", regwrite_wb); end
        checks++; if (mem_err !== 1'b0) begin errors++; $display("FAIL midrst_err: got %b expected 0", mem_err); end
        @(negedge clk);
        drive_nop();
        rst = 1'b1;
        #1;
        checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL midrst_idle: got req=%b expected 0", dmem_req); end
        @(negedge clk);
        checks++; if (dmem_req !== 1'b0 || mem_stall !== 1'b0) begin
            errors++; $display("FAIL midrst_idle_hold: got req=%b stall=%b expected 0/0", dmem_req, mem_stall);
        end
    endtask

    initial begin
        test_reset();
        test_alu_op();
        test_store_zero_wait();
        test_load_wait();
        test_load_store_both();
        test_timeout();
        test_reset_mid_access();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
